// File: rtl/fibo_pkg.sv
// Shared types and defaults for the Fibonacci engine arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fibo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fibo_arb_state_t;

  localparam int FIBO_N_W    = 5;
  localparam int FIBO_DATA_W = 16;

  // Wraps an index in [0, 2*num) back into [0, num). Round-robin pointers
  // only ever overshoot by less than one lap, so one subtraction suffices.
  function automatic int rr_wrap(input int idx, input int num);
    return (idx >= num) ? (idx - num) : idx;
  endfunction

endpackage

// File: rtl/fibo_arbiter_if.sv
// Bundle of every request, response and engine signal around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: resp_ready stalls the response channel; req_ready is the grant.
// Ports: master = the arbiter itself; slave = clients, response sink and engine.
interface fibo_arbiter_if
  import fibo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int N_W     = FIBO_N_W,
  parameter int DATA_W  = FIBO_DATA_W
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*N_W-1:0] req_n;
  logic [NUM_REQ-1:0]     req_ready;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_err;

  logic                   eng_start;
  logic [N_W-1:0]         eng_n;
  logic [DATA_W-1:0]      eng_result;
  logic                   eng_done;

  logic                   busy;

  modport master (
    input  req_valid, req_n, resp_ready, eng_result, eng_done,
    output req_ready, resp_valid, resp_id, resp_data, resp_err,
           eng_start, eng_n, busy
  );

  modport slave (
    output req_valid, req_n, resp_ready, eng_result, eng_done,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err,
           eng_start, eng_n, busy
  );

endinterface

// File: rtl/rr_picker.sv
// One-hot round-robin select: first asserted req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is asserted.
// Ports: req (request vector), ptr (highest-priority index) -> gnt, gnt_id, any.
module rr_picker
  import fibo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fibo_arbiter.sv
// Shares one Fibonacci engine among NUM_REQ requesters, round-robin, one job at a time.
// Latency: accept at T, eng_start at T+1, response the cycle after eng_done (n==0: T+1).
// Backpressure: response held in RESP until resp_ready; no new grant until then.
// Ports: clk, reset_n (async active-low), bus (requests, response, engine, busy).
// ID_W must equal $clog2(NUM_REQ); TIMEOUT >= 2.
module fibo_arbiter
  import fibo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int N_W     = FIBO_N_W,
  parameter int DATA_W  = FIBO_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  fibo_arbiter_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  fibo_arb_state_t     state;
  logic [ID_W-1:0]     rr_ptr;
  logic [TMR_W-1:0]    timer;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_any;
  logic [N_W-1:0]      gnt_n;
  logic [ID_W-1:0]     ptr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Grant is only offered while idle; the transfer completes in that cycle.
  assign bus.req_ready = (state == ST_IDLE) ? gnt : '0;

  // Only the winner's index is ever looked at.
  assign gnt_n = bus.req_n[int'(gnt_id)*N_W +: N_W];

  // After serving id, priority starts at the next requester.
  assign ptr_next = ID_W'(rr_wrap(int'(bus.resp_id) + 1, NUM_REQ));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      timer          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      bus.eng_start  <= 1'b0;
      bus.eng_n      <= '0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            bus.resp_id <= gnt_id;
            bus.eng_n   <= gnt_n;
            bus.busy    <= 1'b1;
            if (gnt_n == '0) begin
              // fib(0) is known; skip the engine entirely.
              bus.resp_data  <= '0;
              bus.resp_err   <= 1'b0;
              bus.resp_valid <= 1'b1;
              state          <= ST_RESP;
            end else begin
              bus.eng_start <= 1'b1;
              state         <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          bus.eng_start <= 1'b0;
          timer         <= '0;
          state         <= ST_WAIT;
        end

        ST_WAIT: begin
          timer <= timer + 1'b1;
          // Done is checked first so a completion on the last allowed cycle
          // still returns real data.
          if (bus.eng_done) begin
            bus.resp_data  <= bus.eng_result;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.busy       <= 1'b0;
            rr_ptr         <= ptr_next;
            state          <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_arbiter.sv
// Testbench for fibo_arbiter: engine model, grant-driven scoreboard, scenario tasks.
// Latency: n/a.
// Backpressure: resp_ready is driven per scenario.
module tb_fibo_arbiter;
  import fibo_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int N_W     = 5;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fibo_arbiter_if #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .N_W     (N_W),
    .DATA_W  (DATA_W)
  ) bus ();

  fibo_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .N_W     (N_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t           sb[$];
  logic [N_W-1:0] nq[$];
  int             glog[$];

  int eng_delay = 1;
  bit eng_hang  = 1'b0;
  int n_starts  = 0;

  function automatic logic [DATA_W-1:0] fib(input int n);
    logic [DATA_W-1:0] a, b, t;
    a = '0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [N_W-1:0] n);
    bus.req_n[id*N_W +: N_W] = n;
  endtask

  // Raises one request in an idle cycle and counts cycles until resp_valid.
  task automatic run_one(input int id, input logic [N_W-1:0] n, output int lat);
    set_req(id, n);
    bus.req_valid = NUM_REQ'(1) << id;
    step();
    bus.req_valid = '0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (i < 500 && (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || sb.size() != 0)) begin
      step();
      i++;
    end
    n_cmp++;
    if (i >= 500) begin
      n_bad++;
      $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, required idle", tag, bus.busy, sb.size(), i);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset_n = 1'b0;
    sb.delete();
    nq.delete();
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  // Scoreboard producer: every grant pushes the response the requester must get.
  int             g_id;
  logic [N_W-1:0] g_n;
  exp_t           g_e;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.req_ready !== '0) begin
      n_cmp++;
      if ($countones(bus.req_ready) != 1) begin
        n_bad++;
        $display("FAIL grant_onehot: req_ready=%b, required exactly one bit", bus.req_ready);
      end
      g_id = 0;
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g_id = i;
      g_n      = bus.req_n[g_id*N_W +: N_W];
      g_e.id   = ID_W'(g_id);
      g_e.err  = (g_n != '0) && eng_hang;
      g_e.data = (g_n == '0 || eng_hang) ? '0 : fib(int'(g_n));
      sb.push_back(g_e);
      glog.push_back(g_id);
      if (g_n != '0) nq.push_back(g_n);
    end
  end

  // Scoreboard consumer: compares each accepted response.
  exp_t r_e;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: id=%0d data=%0d err=%b, required no response", bus.resp_id, bus.resp_data, bus.resp_err);
      end else begin
        r_e = sb.pop_front();
        if (bus.resp_id !== r_e.id || bus.resp_data !== r_e.data || bus.resp_err !== r_e.err) begin
          n_bad++;
          $display("FAIL resp_content: got id=%0d data=%0d err=%b, required id=%0d data=%0d err=%b",
                   bus.resp_id, bus.resp_data, bus.resp_err, r_e.id, r_e.data, r_e.err);
        end
      end
    end
  end

  // Engine model: answers each start after eng_delay cycles unless hung.
  logic [N_W-1:0] e_n;
  initial begin
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    forever begin
      step();
      if (reset_n === 1'b1 && bus.eng_start === 1'b1) begin
        n_starts++;
        e_n = bus.eng_n;
        n_cmp++;
        if (nq.size() == 0) begin
          n_bad++;
          $display("FAIL eng_unexpected_start: eng_n=%0d, required no start", bus.eng_n);
        end else if (nq[0] !== e_n) begin
          n_bad++;
          $display("FAIL eng_n: got %0d, required %0d", e_n, nq[0]);
          void'(nq.pop_front());
        end else begin
          void'(nq.pop_front());
        end
        if (!eng_hang) begin
          repeat (eng_delay) @(posedge clk);
          #1;
          bus.eng_result = fib(int'(e_n));
          bus.eng_done   = 1'b1;
          step();
          bus.eng_done   = 1'b0;
          bus.eng_result = '0;
        end
      end
    end
  end

  task automatic test_reset();
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err,
         bus.eng_start, bus.eng_n, bus.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d data=%0d err=%b start=%b n=%0d busy=%b, required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err,
               bus.eng_start, bus.eng_n, bus.busy);
    end
    reset_n = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b resp_valid=%b, required 0/0", bus.busy, bus.resp_valid);
    end
  endtask

  task automatic test_single();
    int g0, s0, lat;
    eng_delay = 9;
    eng_hang  = 1'b0;
    g0 = glog.size();
    s0 = n_starts;
    set_req(0, 10);
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_grant: req_ready=%b, required 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.eng_start !== 1'b1 || bus.eng_n !== 5'd10 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_start: start=%b eng_n=%0d busy=%b, required 1/10/1", bus.eng_start, bus.eng_n, bus.busy);
    end
    step();
    n_cmp++;
    if (bus.eng_start !== 1'b0) begin
      n_bad++;
      $display("FAIL single_start_pulse: eng_start=%b one cycle later, required 0", bus.eng_start);
    end
    lat = 2;
    while (bus.resp_valid !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    n_cmp++;
    if (lat != 11) begin
      n_bad++;
      $display("FAIL single_latency: resp_valid %0d cycles after accept, required 11", lat);
    end
    n_cmp++;
    if (bus.resp_id !== 2'd0 || bus.resp_data !== 16'd55 || bus.resp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_resp: id=%0d data=%0d err=%b, required 0/55/0", bus.resp_id, bus.resp_data, bus.resp_err);
    end
    wait_idle("single");
    n_cmp++;
    if (glog.size() - g0 != 1 || n_starts - s0 != 1) begin
      n_bad++;
      $display("FAIL single_counts: grants=%0d starts=%0d, required 1/1", glog.size() - g0, n_starts - s0);
    end
  endtask

  task automatic test_round_robin();
    int g0, i;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    eng_delay = 2;
    set_req(0, 3);
    set_req(1, 5);
    set_req(2, 7);
    set_req(3, 9);
    g0 = glog.size();
    bus.req_valid = 4'b1111;
    i = 0;
    while (glog.size() - g0 < 5 && i < 400) begin
      step();
      i++;
    end
    bus.req_valid = '0;
    wait_idle("rr");
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (glog.size() <= g0 + k) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: no grant seen, required id %0d", k, exp_order[k]);
      end else if (glog[g0 + k] != exp_order[k]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got id %0d, required id %0d", k, glog[g0 + k], exp_order[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0, i;
    eng_delay = 3;
    set_req(1, 6);
    set_req(3, 1);
    bus.resp_ready = 1'b0;
    g0 = glog.size();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1000;
    i = 0;
    while (bus.resp_valid !== 1'b1 && i < 300) begin
      step();
      i++;
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_data !== 16'd8 ||
          bus.resp_err !== 1'b0 || bus.req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b id=%0d data=%0d err=%b rdy=%b, required 1/1/8/0/0000",
                 c, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err, bus.req_ready);
      end
      step();
    end
    bus.resp_ready = 1'b1;
    i = 0;
    while (glog.size() - g0 < 2 && i < 50) begin
      step();
      i++;
    end
    bus.req_valid = '0;
    wait_idle("bp");
    n_cmp++;
    if (glog.size() - g0 != 2 || glog[g0 + 1] != 3) begin
      n_bad++;
      $display("FAIL bp_next_grant: grants=%0d, required 2 with second to id 3", glog.size() - g0);
    end
  endtask

  task automatic test_timeout();
    int lat;
    eng_hang = 1'b1;
    run_one(0, 5, lat);
    n_cmp++;
    if (lat != TIMEOUT + 2 || bus.resp_err !== 1'b1 || bus.resp_data !== '0) begin
      n_bad++;
      $display("FAIL timeout_resp: lat=%0d err=%b data=%0d, required lat=%0d err=1 data=0",
               lat, bus.resp_err, bus.resp_data, TIMEOUT + 2);
    end
    wait_idle("timeout");
    eng_hang  = 1'b0;
    eng_delay = 3;
    run_one(2, 7, lat);
    n_cmp++;
    if (lat != 5 || bus.resp_err !== 1'b0 || bus.resp_data !== 16'd13) begin
      n_bad++;
      $display("FAIL after_timeout: lat=%0d err=%b data=%0d, required 5/0/13", lat, bus.resp_err, bus.resp_data);
    end
    wait_idle("after_timeout");
    eng_delay = TIMEOUT;
    run_one(1, 12, lat);
    n_cmp++;
    if (lat != TIMEOUT + 2 || bus.resp_err !== 1'b0 || bus.resp_data !== 16'd144) begin
      n_bad++;
      $display("FAIL done_at_timeout: lat=%0d err=%b data=%0d, required lat=%0d err=0 data=144",
               lat, bus.resp_err, bus.resp_data, TIMEOUT + 2);
    end
    wait_idle("done_at_timeout");
  endtask

  task automatic test_n_zero();
    int s0, lat;
    s0 = n_starts;
    run_one(2, 0, lat);
    n_cmp++;
    if (lat != 1 || bus.resp_id !== 2'd2 || bus.resp_data !== '0 || bus.resp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL nzero_resp: lat=%0d id=%0d data=%0d err=%b, required 1/2/0/0", lat, bus.resp_id, bus.resp_data, bus.resp_err);
    end
    wait_idle("nzero");
    n_cmp++;
    if (n_starts != s0) begin
      n_bad++;
      $display("FAIL nzero_no_start: %0d engine starts, required 0", n_starts - s0);
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    eng_delay = 20;
    set_req(1, 9);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    repeat (4) step();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy: busy=%b before reset, required 1", bus.busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err,
         bus.eng_start, bus.eng_n, bus.busy} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: vld=%b id=%0d start=%b n=%0d busy=%b, required all 0",
               bus.resp_valid, bus.resp_id, bus.eng_start, bus.eng_n, bus.busy);
    end
    sb.delete();
    nq.delete();
    step();
    step();
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      step();
      if (bus.resp_valid === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL rstmid_stale: activity seen after reset release, required none");
    end
    set_req(0, 4);
    set_req(2, 2);
    set_req(3, 3);
    eng_delay = 2;
    bus.req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rstmid_first_grant: req_ready=%b, required 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    wait_idle("rstmid");
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_n      = '0;
    bus.resp_ready = 1'b1;
    repeat (3) step();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_n_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fibo_arbiter.md
Name: fibo_arbiter

Overview:
- Shares one Fibonacci compute engine among NUM_REQ independent requesters.
- Arbitrates round-robin and accepts one request at a time.
- Sequences the engine's start/done handshake and guards it with a timeout.
- Returns the result, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and the single engine instance; only this block drives the engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must equal $clog2(NUM_REQ)
- N_W, 5, width of the Fibonacci index
- DATA_W, 16, result width
- TIMEOUT, 64, max cycles in WAIT before the engine is declared hung (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_n  in  NUM_REQ*N_W  packed indices; requester i occupies bits [i*N_W +: N_W]
- req_ready  out  NUM_REQ  one-hot accept to the winning requester
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  ID_W  requester that owns the response
- resp_data  out  DATA_W  Fibonacci result
- resp_err  out  1  1 = engine timed out; resp_data is 0
- eng_start  out  1  one-cycle start pulse to the engine
- eng_n  out  N_W  index presented to the engine, stable from eng_start until done/timeout
- eng_result  in  DATA_W  engine result, valid when eng_done=1
- eng_done  in  1  engine completion pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0, timer=0.
  - Outputs req_ready, resp_valid, resp_id, resp_data, resp_err, eng_start, eng_n and busy are all 0.
  - Reset mid-operation abandons any transaction; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot winner, asserted only in IDLE; the transfer completes in that cycle.
  - On transfer, latch the ID and req_n slice.
  - If n==0: go straight to RESP with data=0, err=0, and no engine start.
  - Otherwise go to ISSUE.
- ISSUE:
  - eng_start=1 for exactly this cycle, with eng_n = latched n.
  - timer <= 0; go to WAIT.
- WAIT:
  - timer increments every cycle.
  - If eng_done=1: capture eng_result into resp_data, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: resp_data=0, err=1, go to RESP.
  - eng_done and timeout in the same cycle: done wins.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are registered and held stable until resp_valid & resp_ready.
  - On the handshake: rr_ptr <= (id+1) mod NUM_REQ, go to IDLE.
  - resp_valid falls in the next cycle, and a new grant may occur in that same cycle.
- eng_done outside WAIT is ignored.
- Latency (engine done at cycle T+k after an accept at T):
  - Accept at T, eng_start at T+1.
  - resp_valid at T+k+1 once eng_done is seen.
  - n==0: resp_valid at T+1.
- Fairness: a continuously asserting requester is granted at most once per NUM_REQ grants while others are pending.
- req_valid deasserted before being granted is legal; the request is simply not taken. Only the req_n of the granted requester is sampled.
- The block never issues a second eng_start before done/timeout of the previous one.

Decomposition:
- Package fibo_pkg:
  - state enum fibo_arb_state_t (2-bit).
  - Default constants FIBO_N_W=5 and FIBO_DATA_W=16.
- Sub-module rr_picker (one-hot round-robin priority select from req vector and rr_ptr; purely combinational).
- FSM, timer and response registers stay in fibo_arbiter.

Test Plan:
- Single request: req_valid=0001, n=10, engine done after 9 cycles with 55 -> one req_ready pulse; eng_start 1 cycle later with eng_n=10; resp_valid with id=0, data=55, err=0.
- Round robin: all four req_valid held high -> grant order 0,1,2,3,0; each response id matches.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_id and resp_data held stable; no new req_ready until acceptance.
- Timeout: engine never asserts eng_done -> after TIMEOUT cycles in WAIT, resp_err=1 and data=0; next request proceeds normally. Also drive eng_done on exactly the timeout cycle -> err=0 and the engine data is returned.
- n==0 from requester 2 -> no eng_start; resp_valid the next cycle with id=2, data=0.
- Reset asserted during WAIT -> all outputs 0 immediately; no stale response after release; next grant starts from requester 0.
